dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (core port) and a loader/debug port (ldr port).
- Sits between the requesters and data_memory. It drives the memory address, write enable and write data, and returns read data to the winning requester.
- Uses round-robin arbitration. The loader can take a bounded lock for bursts (program load, memory dump).
- Asserts core_stall whenever the MEM stage requests and is not granted.

Parameters:
ADDR_W, 32, address width (byte address)
DATA_W, 32, data word width
MAX_LOCK, 16, maximum consecutive loader grants under lock while the core is waiting; range 1..255

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
core_req  in  1  core access request
core_we  in  1  core write (1) / read (0)
core_addr  in  ADDR_W  core byte address
core_wdata  in  DATA_W  core write data
core_gnt  out  1  core access performed this cycle
core_stall  out  1  core_req & ~core_gnt
core_rvalid  out  1  core read data valid (one cycle after grant)
core_rdata  out  DATA_W  core read data
ldr_req  in  1  loader access request
ldr_lock  in  1  loader requests exclusive burst ownership
ldr_we  in  1  loader write / read
ldr_addr  in  ADDR_W  loader byte address
ldr_wdata  in  DATA_W  loader write data
ldr_gnt  out  1  loader access performed this cycle
ldr_rvalid  out  1  loader read data valid
ldr_rdata  out  DATA_W  loader read data
mem_addr  out  ADDR_W  to data_memory byte_address
mem_we  out  1  to data_memory write_enable
mem_wdata  out  DATA_W  to data_memory write_data
mem_rdata  in  DATA_W  from data_memory read_data (combinational from mem_addr)

Behaviour:
- Reset values (applied while reset=1):
  - state=ARB, rr_last=LDR (so the core wins the first tie), lock_cnt=0.
  - core_rvalid=ldr_rvalid=0; core_rdata=ldr_rdata=0.
  - core_gnt=ldr_gnt=0 and mem_we=0 combinationally while reset=1. No write may occur during reset.
- Grants:
  - Combinational, at most one per cycle; the access completes in the grant cycle.
  - A requester holds req/addr/we/wdata stable until it sees gnt.
- Mux:
  - mem_addr/mem_we/mem_wdata select the granted port.
  - With no grant: mem_we=0, mem_addr=core_addr.
- Read return:
  - On a granted read, mem_rdata is registered into that port's rdata and its rvalid pulses 1 in the next cycle.
  - rdata holds its value until the next read of that port.
  - A write never pulses rvalid.
- State ARB:
  - Single requester: it is granted.
  - Both request: grant the port other than rr_last.
  - rr_last updates to the granted port on every grant.
  - Loader granted with ldr_lock=1: next state LOCKED, lock_cnt=0.
- State LOCKED:
  - ldr_lock=0: arbitrate exactly as ARB this cycle; next state ARB.
  - ldr_lock=1, lock_cnt<MAX_LOCK: the core is never granted; the loader is granted if ldr_req.
    - lock_cnt increments on each loader grant made while core_req=1.
    - lock_cnt does not increment when core_req=0.
  - ldr_lock=1, lock_cnt==MAX_LOCK, core_req=1: forced yield. Grant the core, set lock_cnt=0, stay LOCKED.
  - ldr_req=0 in LOCKED: no grant, lock retained, no counting.
- Simultaneous events:
  - Core and loader request on the same cycle that the loader lock is released: ARB rules apply.
  - Reset asserted mid-lock: the next cycle is ARB with counters cleared. Pending rvalid is dropped.
- core_stall is purely combinational: core_req & ~core_gnt.

Decomposition:
- Shared package (existing core package): arb_state_t enum {ARB, LOCKED} and port_id_t enum {PORT_CORE, PORT_LDR}.
- No sub-module; arbiter FSM, lock counter, mux and read-return registers all live in one module.

Test Plan:
- Reset held 3 cycles with both ports requesting writes → gnt=0, mem_we=0 throughout. First cycle after release grants core (core_gnt=1, ldr_gnt=0).
- Both request continuously, no lock → grants alternate C,L,C,L for 8 cycles. core_stall=1 exactly on loader cycles.
- Core write 0xDEADBEEF to addr 0x40, then core read 0x40 → core_rvalid=1 one cycle after the read grant, core_rdata=0xDEADBEEF, ldr_rvalid stays 0.
- MAX_LOCK=4, loader lock plus continuous ldr_req, core_req held → 4 consecutive loader grants (after the lock-taking grant), then 1 core grant, then loader again. Repeats while lock held.
- Loader locked, core_req=0 for 10 cycles → 10 loader grants, no forced yield. Core then requests → yields after MAX_LOCK more loader grants.
- Reset pulsed while LOCKED with an outstanding loader read → ldr_rvalid=0 next cycle, state ARB, core wins the first tie.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states and port identifiers.
package dmem_arbiter_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_LDR  = 1'b1
  } port_id_t;

  // Width of the loader lock counter; holds values up to 255.
  localparam int LOCK_CNT_W = 8;

endpackage

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the MEM
// stage (core port) and the loader/debug port. The loader may hold a
// bounded lock for bursts. While the core is kept waiting, the core is
// forced through after MAX_LOCK loader grants.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ldr_req,
  input  logic              ldr_lock,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [LOCK_CNT_W-1:0] MAX_LOCK_C = LOCK_CNT_W'(MAX_LOCK);

  arb_state_t            state, state_nxt;
  port_id_t              rr_last, rr_nxt;
  logic [LOCK_CNT_W-1:0] lock_cnt, cnt_nxt;
  logic                  do_arb;

  // Grant decision, next-state and lock-counter update. Under reset no grant is made.
  always_comb begin
    core_gnt  = 1'b0;
    ldr_gnt   = 1'b0;
    state_nxt = state;
    rr_nxt    = rr_last;
    cnt_nxt   = lock_cnt;
    do_arb    = 1'b0;
    if (reset) begin
      state_nxt = ARB;
    end else begin
      case (state)
        ARB: begin
          do_arb = 1'b1;
        end
        LOCKED: begin
          if (!ldr_lock) begin
            // Lock released: plain round-robin this cycle, then back to ARB.
            do_arb    = 1'b1;
            state_nxt = ARB;
          end else if (core_req && (lock_cnt == MAX_LOCK_C)) begin
            // Forced yield to a core that has waited MAX_LOCK loader grants.
            core_gnt = 1'b1;
            cnt_nxt  = '0;
          end else if (ldr_req) begin
            ldr_gnt = 1'b1;
            if (core_req) begin
              cnt_nxt = lock_cnt + 8'd1;
            end else begin
              cnt_nxt = lock_cnt;
            end
          end else begin
            // Loader idle but still holding the lock: no grant, no counting.
            cnt_nxt = lock_cnt;
          end
        end
        default: begin
          state_nxt = ARB;
        end
      endcase

      if (do_arb) begin
        if (core_req && ldr_req) begin
          if (rr_last == PORT_LDR) begin
            core_gnt = 1'b1;
          end else begin
            ldr_gnt = 1'b1;
          end
        end else if (core_req) begin
          core_gnt = 1'b1;
        end else if (ldr_req) begin
          ldr_gnt = 1'b1;
        end else begin
          core_gnt = 1'b0;
        end
        if (ldr_gnt && ldr_lock) begin
          state_nxt = LOCKED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_nxt;
        end
      end else begin
        do_arb = 1'b0;
      end

      if (core_gnt) begin
        rr_nxt = PORT_CORE;
      end else if (ldr_gnt) begin
        rr_nxt = PORT_LDR;
      end else begin
        rr_nxt = rr_last;
      end
    end
  end

  // Memory-side mux: the granted port drives the memory; idle defaults to the core address.
  always_comb begin
    mem_addr   = core_addr;
    mem_wdata  = core_wdata;
    mem_we     = 1'b0;
    if (ldr_gnt) begin
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
      mem_we    = ldr_we;
    end else if (core_gnt) begin
      mem_we = core_we;
    end else begin
      mem_we = 1'b0;
    end
    core_stall = core_req & ~core_gnt;
  end

  // Arbiter state, round-robin pointer and lock counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB;
      rr_last  <= PORT_LDR;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_last  <= rr_nxt;
      lock_cnt <= cnt_nxt;
    end
  end

  // Read-return registers: capture memory data on a granted read, pulse rvalid next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_rvalid <= 1'b0;
      ldr_rvalid  <= 1'b0;
      core_rdata  <= '0;
      ldr_rdata   <= '0;
    end else begin
      core_rvalid <= core_gnt & ~core_we;
      ldr_rvalid  <= ldr_gnt & ~ldr_we;
      if (core_gnt && !core_we) begin
        core_rdata <= mem_rdata;
      end else begin
        core_rdata <= core_rdata;
      end
      if (ldr_gnt && !ldr_we) begin
        ldr_rdata <= mem_rdata;
      end else begin
        ldr_rdata <= ldr_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (MAX_LOCK = 4) with a
// small behavioural data memory attached to the memory port.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic        core_gnt, core_stall, core_rvalid;
  logic [31:0] core_rdata;
  logic        ldr_req, ldr_lock, ldr_we;
  logic [31:0] ldr_addr, ldr_wdata;
  logic        ldr_gnt, ldr_rvalid;
  logic [31:0] ldr_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem [0:63];
  int          n_pass;
  int          n_total;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(4)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .ldr_req(ldr_req), .ldr_lock(ldr_lock), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port memory: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    // Reset held three cycles with both ports requesting writes.
    reset = 1'b1;
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h0000_0000; core_wdata = 32'h1111_1111;
    ldr_req  = 1'b1; ldr_lock = 1'b0; ldr_we = 1'b1; ldr_addr = 32'h0000_0004; ldr_wdata = 32'h2222_2222;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_core_gnt", {31'b0, core_gnt}, 32'd0);
      chk("rst_ldr_gnt",  {31'b0, ldr_gnt},  32'd0);
      chk("rst_mem_we",   {31'b0, mem_we},   32'd0);
      tick();
    end
    chk("rst_core_rvalid", {31'b0, core_rvalid}, 32'd0);
    chk("rst_ldr_rvalid",  {31'b0, ldr_rvalid},  32'd0);
    chk("rst_core_rdata",  core_rdata, 32'd0);
    chk("rst_ldr_rdata",   ldr_rdata,  32'd0);
    reset = 1'b0;

    // Both requesting, no lock: core first, then strict alternation.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("alt_core_gnt",   {31'b0, core_gnt},   (c % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_ldr_gnt",    {31'b0, ldr_gnt},    (c % 2 == 1) ? 32'd1 : 32'd0);
      chk("alt_core_stall", {31'b0, core_stall}, (c % 2 == 1) ? 32'd1 : 32'd0);
      chk("alt_mem_addr",   mem_addr, (c % 2 == 0) ? 32'h0 : 32'h4);
      tick();
    end

    // Core write then read of 0x40.
    ldr_req = 1'b0;
    core_we = 1'b1; core_addr = 32'h0000_0040; core_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wr_core_gnt",  {31'b0, core_gnt}, 32'd1);
    chk("wr_mem_we",    {31'b0, mem_we},   32'd1);
    chk("wr_mem_addr",  mem_addr,  32'h40);
    chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    core_we = 1'b0;
    @(negedge clk);
    chk("rd_core_gnt",       {31'b0, core_gnt},    32'd1);
    chk("rd_mem_we",         {31'b0, mem_we},      32'd0);
    chk("wr_no_core_rvalid", {31'b0, core_rvalid}, 32'd0);
    tick();
    core_req = 1'b0;
    @(negedge clk);
    chk("rd_core_rvalid", {31'b0, core_rvalid}, 32'd1);
    chk("rd_core_rdata",  core_rdata, 32'hDEAD_BEEF);
    chk("rd_ldr_rvalid",  {31'b0, ldr_rvalid},  32'd0);
    tick();
    @(negedge clk);
    chk("rd_rvalid_pulse", {31'b0, core_rvalid}, 32'd0);
    chk("rd_rdata_hold",   core_rdata, 32'hDEAD_BEEF);
    tick();

    // Loader lock with the core waiting: lock grant, 4 loader, core, 4 loader, core.
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0040;
    ldr_req  = 1'b1; ldr_lock = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h0000_0040;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      chk("lock_core_gnt", {31'b0, core_gnt}, (c != 0 && c % 5 == 0) ? 32'd1 : 32'd0);
      chk("lock_ldr_gnt",  {31'b0, ldr_gnt},  (c != 0 && c % 5 == 0) ? 32'd0 : 32'd1);
      if (c == 1) begin
        chk("lock_ldr_rvalid", {31'b0, ldr_rvalid}, 32'd1);
        chk("lock_ldr_rdata",  ldr_rdata, 32'hDEAD_BEEF);
      end
      tick();
    end

    // Still locked, core idle: ten loader grants, no counting toward a yield.
    core_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_ldr_gnt",  {31'b0, ldr_gnt},  32'd1);
      chk("idle_core_gnt", {31'b0, core_gnt}, 32'd0);
      tick();
    end
    core_req = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      chk("yield_core_gnt", {31'b0, core_gnt}, (c == 4) ? 32'd1 : 32'd0);
      chk("yield_ldr_gnt",  {31'b0, ldr_gnt},  (c == 4) ? 32'd0 : 32'd1);
      tick();
    end

    // Loader read granted in LOCKED, then reset while the loader keeps requesting.
    core_req = 1'b0; ldr_addr = 32'h0000_0000;
    @(negedge clk);
    chk("pre_rst_ldr_gnt", {31'b0, ldr_gnt}, 32'd1);
    tick();
    reset = 1'b1; core_req = 1'b1;
    @(negedge clk);
    chk("mid_rst_ldr_gnt",    {31'b0, ldr_gnt},    32'd0);
    chk("mid_rst_core_gnt",   {31'b0, core_gnt},   32'd0);
    chk("mid_rst_ldr_rvalid", {31'b0, ldr_rvalid}, 32'd1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ldr_rvalid", {31'b0, ldr_rvalid}, 32'd0);
    chk("post_rst_core_gnt",   {31'b0, core_gnt},   32'd1);
    chk("post_rst_ldr_gnt",    {31'b0, ldr_gnt},    32'd0);
    tick();
    @(negedge clk);
    chk("post_rst_rr_ldr_gnt", {31'b0, ldr_gnt}, 32'd1);
    chk("post_rst_rr_stall",   {31'b0, core_stall}, 32'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
